// File: rtl/truco_hand_tracker.sv
// rtl/truco_hand_tracker.sv - truco hand round history, round counter and winner decision
//
// Records each round result of a truco hand into a per-slot history
// register, counts rounds, decides the hand winner and flags completion.
//
// Optional feature macro: TRUCO_EARLY_END_EN (early decision when the
// trailing team can no longer catch up).
//
// Parameters:
//   NUM_ROUNDS  rounds per hand (odd, >= 1)
//   RW          round counter width (derived)
// Ports:
//   clk          system clock, rising edge
//   clr          asynchronous active-high reset
//   hand_start   strobe: clear history and begin a hand
//   win1/win2    strobe: current round won by team 1 / team 2
//   draw         strobe: current round drawn
//   hist         slot k = [2k+1:2k]: 00 not played, 01 t1, 10 t2, 11 draw
//   round_idx    rounds recorded in the current hand
//   hand_done    level, high while the hand is decided
//   done_pulse   one-cycle pulse when the hand becomes decided
//   hand_winner  00 none, 01 team 1, 10 team 2, 11 tied hand
//   err          one-cycle pulse on more than one result strobe in PLAY
module truco_hand_tracker #(
    parameter int NUM_ROUNDS = 3,
    parameter int RW         = $clog2(NUM_ROUNDS + 1)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    hand_start,
    input  logic                    win1,
    input  logic                    win2,
    input  logic                    draw,
    output logic [2*NUM_ROUNDS-1:0] hist,
    output logic [RW-1:0]           round_idx,
    output logic                    hand_done,
    output logic                    done_pulse,
    output logic [1:0]              hand_winner,
    output logic                    err
);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    localparam logic [RW-1:0] M_W = RW'(NUM_ROUNDS / 2 + 1);
    localparam logic [RW-1:0] N_W = RW'(NUM_ROUNDS);

    state_t                  state, state_n;
    logic [2*NUM_ROUNDS-1:0] hist_n;
    logic [RW-1:0]           round_idx_n;
    logic [RW-1:0]           c1, c1_n, c2, c2_n;
    logic [1:0]              tb_holder, tb_holder_n;
    logic [1:0]              hand_winner_n;
    logic                    hand_done_n, done_pulse_n, err_n;
    logic                    multi, single, decided;
    logic [1:0]              code;
`ifdef TRUCO_EARLY_END_EN
    logic [RW-1:0]           rem, diff;
    logic [1:0]              lead;
`endif

    assign multi  = (win1 & win2) | (win1 & draw) | (win2 & draw);
    assign single = (win1 | win2 | draw) & ~multi;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            hist        <= '0;
            round_idx   <= '0;
            c1          <= '0;
            c2          <= '0;
            tb_holder   <= 2'b00;
            hand_winner <= 2'b00;
            hand_done   <= 1'b0;
            done_pulse  <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            hist        <= hist_n;
            round_idx   <= round_idx_n;
            c1          <= c1_n;
            c2          <= c2_n;
            tb_holder   <= tb_holder_n;
            hand_winner <= hand_winner_n;
            hand_done   <= hand_done_n;
            done_pulse  <= done_pulse_n;
            err         <= err_n;
        end
    end

    always_comb begin
        state_n       = state;
        hist_n        = hist;
        round_idx_n   = round_idx;
        c1_n          = c1;
        c2_n          = c2;
        tb_holder_n   = tb_holder;
        hand_winner_n = hand_winner;
        hand_done_n   = hand_done;
        done_pulse_n  = 1'b0;
        err_n         = 1'b0;
        decided       = 1'b0;
        code          = 2'b00;
`ifdef TRUCO_EARLY_END_EN
        rem           = '0;
        diff          = '0;
        lead          = 2'b00;
`endif
        if (hand_start) begin
            // Any result strobe in this cycle belongs to no hand and is dropped.
            state_n       = PLAY;
            hist_n        = '0;
            round_idx_n   = '0;
            c1_n          = '0;
            c2_n          = '0;
            tb_holder_n   = 2'b00;
            hand_winner_n = 2'b00;
            hand_done_n   = 1'b0;
        end else if (state == PLAY) begin
            if (multi) begin
                err_n = 1'b1;
            end else if (single) begin
                code = win1 ? 2'b01 : (win2 ? 2'b10 : 2'b11);
                for (int k = 0; k < NUM_ROUNDS; k++) begin
                    if (round_idx == RW'(k)) hist_n[2*k +: 2] = code;
                end
                round_idx_n = round_idx + 1'b1;
                if (win1) c1_n = c1 + 1'b1;
                if (win2) c2_n = c2 + 1'b1;
                // First non-draw round owns the tie-break for the rest of the hand.
                if (tb_holder == 2'b00 && !draw) tb_holder_n = code;

                decided = (c1_n >= M_W) || (c2_n >= M_W) || (round_idx_n == N_W);
`ifdef TRUCO_EARLY_END_EN
                // Remaining rounds cannot overturn the leader.
                rem  = N_W - round_idx_n;
                diff = (c1_n > c2_n) ? (c1_n - c2_n) : (c2_n - c1_n);
                lead = (c1_n > c2_n) ? 2'b01 : 2'b10;
                if ((diff > rem) || ((diff == rem) && (rem != '0) && (lead == tb_holder_n)))
                    decided = 1'b1;
`endif
                if (decided) begin
                    state_n      = DONE;
                    hand_done_n  = 1'b1;
                    done_pulse_n = 1'b1;
                    if (c1_n > c2_n)
                        hand_winner_n = 2'b01;
                    else if (c2_n > c1_n)
                        hand_winner_n = 2'b10;
                    else if (tb_holder_n != 2'b00)
                        hand_winner_n = tb_holder_n;
                    else
                        hand_winner_n = 2'b11;
                end
            end
        end
    end

endmodule

// File: tb/tb_truco_hand_tracker.sv
// tb/tb_truco_hand_tracker.sv - scoreboard bench for truco_hand_tracker
module tb_truco_hand_tracker;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       hand_start = 1'b0;
    logic       win1 = 1'b0;
    logic       win2 = 1'b0;
    logic       draw = 1'b0;
    logic [5:0] hist;
    logic [1:0] round_idx;
    logic       hand_done;
    logic       done_pulse;
    logic [1:0] hand_winner;
    logic       err;

    typedef struct {
        bit         is_err;
        logic [5:0] hist;
        logic [1:0] ridx;
        logic [1:0] win;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    truco_hand_tracker #(.NUM_ROUNDS(3)) dut (
        .clk         (clk),
        .clr         (clr),
        .hand_start  (hand_start),
        .win1        (win1),
        .win2        (win2),
        .draw        (draw),
        .hist        (hist),
        .round_idx   (round_idx),
        .hand_done   (hand_done),
        .done_pulse  (done_pulse),
        .hand_winner (hand_winner),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs; returns just after the edge that samples them.
    task automatic step(input logic hs, input logic w1, input logic w2, input logic d);
        hand_start = hs;
        win1       = w1;
        win2       = w2;
        draw       = d;
        @(posedge clk);
        #1;
        hand_start = 1'b0;
        win1       = 1'b0;
        win2       = 1'b0;
        draw       = 1'b0;
    endtask

    task automatic push(input bit is_err, input logic [5:0] h, input logic [1:0] r, input logic [1:0] w);
        exp_t e;
        e.is_err = is_err;
        e.hist   = h;
        e.ridx   = r;
        e.win    = w;
        exp_q.push_back(e);
    endtask

    // Monitor: every done_pulse or err event is matched against the scoreboard.
    always @(negedge clk) begin
        if (!clr && (done_pulse || err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, done_pulse, err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_kind", {30'd0, done_pulse, err}, e.is_err ? 32'd1 : 32'd2);
                check("ev_hist", {26'd0, hist}, {26'd0, e.hist});
                check("ev_round_idx", {30'd0, round_idx}, {30'd0, e.ridx});
                check("ev_winner", {30'd0, hand_winner}, {30'd0, e.win});
                if (!e.is_err) check("ev_hand_done", {31'd0, hand_done}, 32'd1);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_hist", {26'd0, hist}, 32'd0);
        check("rst_round_idx", {30'd0, round_idx}, 32'd0);
        check("rst_hand_done", {31'd0, hand_done}, 32'd0);
        check("rst_winner", {30'd0, hand_winner}, 32'd0);
        check("rst_pulses", {30'd0, done_pulse, err}, 32'd0);
        clr = 1'b0;

        // win1, win1: team 1 reaches majority after two rounds
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        push(0, 6'h05, 2'd2, 2'b01);
        step(0, 1, 0, 0);
        @(posedge clk);
        #1;
        check("t1_pulse_one_cycle", {31'd0, done_pulse}, 32'd0);
        check("t1_hand_done_level", {31'd0, hand_done}, 32'd1);
        check("t1_slot2_empty", {30'd0, hist[5:4]}, 32'd0);

        // win2, win1, draw: tie resolved by first non-draw (team 2)
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        push(0, 6'h36, 2'd3, 2'b10);
        step(0, 0, 0, 1);

        // all draws: tied hand
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        push(0, 6'h3F, 2'd3, 2'b11);
        step(0, 0, 0, 1);

        // draw, win1: early end only when the feature is built in
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
`ifdef TRUCO_EARLY_END_EN
        push(0, 6'h07, 2'd2, 2'b01);
        step(0, 1, 0, 0);
        check("t4_hand_done", {31'd0, hand_done}, 32'd1);
`else
        step(0, 1, 0, 0);
        check("t4_hand_done", {31'd0, hand_done}, 32'd0);
        check("t4_round_idx", {30'd0, round_idx}, 32'd2);
        check("t4_hist", {26'd0, hist}, 32'h07);
`endif

        // illegal strobe combination in PLAY, then strobe in DONE
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        push(1, 6'h01, 2'd1, 2'b00);
        step(0, 1, 1, 0);
        @(posedge clk);
        #1;
        check("t5_err_one_cycle", {31'd0, err}, 32'd0);
        check("t5_round_idx_kept", {30'd0, round_idx}, 32'd1);
        push(0, 6'h05, 2'd2, 2'b01);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("t5_done_ignore_err", {31'd0, err}, 32'd0);
        check("t5_done_ignore_idx", {30'd0, round_idx}, 32'd2);
        check("t5_done_ignore_hist", {26'd0, hist}, 32'h05);

        // asynchronous clear mid-hand
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        clr = 1'b1;
        #1;
        check("t6_async_hist", {26'd0, hist}, 32'd0);
        check("t6_async_idx", {30'd0, round_idx}, 32'd0);
        check("t6_async_outs", {28'd0, hand_done, done_pulse, hand_winner[1] | hand_winner[0], err}, 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        step(0, 1, 0, 0);
        check("t6_idle_ignore_idx", {30'd0, round_idx}, 32'd0);
        check("t6_idle_ignore_hist", {26'd0, hist}, 32'd0);
        step(0, 1, 1, 0);
        check("t6_idle_no_err", {31'd0, err}, 32'd0);
        check("t6_idle_not_done", {31'd0, hand_done}, 32'd0);

        // fresh hand after clear: team 2 wins straight
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        push(0, 6'h0A, 2'd2, 2'b10);
        step(0, 0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
